dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter for the single-port DataMemory: CPU datapath (port A) and loader/DMA (port B).
//  Picks one requester per cycle and drives the memory's address/mem_read/mem_write/write_data pins.
//  Registers read data back to the winning port and flags out-of-range addresses.
//  Guarantees port B service under load via an anti-starvation counter, and supports a lock for read-modify-write.
// PARAMETERS
//  MEM_SIZE  128  number of valid words; word addresses >= MEM_SIZE are out of range
//  MAX_WAIT  4    cycles port B may be denied while requesting before it is forced (1..15)
// PORTS
//  clk             in   1   single clock, all state on rising edge
//  rst             in   1   asynchronous, active-low reset (0 = reset)
//  a_req/b_req     in   1   access request; held until gnt seen
//  a_we/b_we       in   1   1 = write, 0 = read
//  a_lock/b_lock   in   1   hold grant for the next cycle too (sampled while granted)
//  a_addr/b_addr   in   32  word address
//  a_wdata/b_wdata in   32  write data
//  a_gnt/b_gnt     out  1   combinational grant; the access completes at this cycle's clock edge
//  a_rvalid/b_rvalid out 1  one-cycle pulse, cycle after a granted read
//  a_rdata/b_rdata out  32  registered read data; valid when rvalid is 1, else holds
//  a_err/b_err     out  1   one-cycle pulse, cycle after a granted out-of-range access
//  mem_address     out  32  to DataMemory.address (0 when idle)
//  mem_read        out  1   to DataMemory.mem_read
//  mem_write       out  1   to DataMemory.mem_write (never 1 for out-of-range)
//  mem_write_data  out  32  to DataMemory.write_data
//  mem_read_data   in   32  from DataMemory.read_data (combinational)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, wait_cnt=0, prio=A; all rvalid/err/rdata=0.
//    Any read in flight is discarded; no rvalid after reset release.
//  - FSM states: IDLE, LOCK_A, LOCK_B.
//    - IDLE: grant by priority among requesters.
//    - LOCK_x: only x may be granted; other port gnt=0.
//    - In LOCK_x with x_req=0, x_gnt=0 and state returns to IDLE next cycle (lost cycle).
//    - Granted x with x_lock=1 -> LOCK_x; granted x with x_lock=0 -> IDLE.
//  - Priority in IDLE, default fixed: A beats B.
//    - Exception: B forced when wait_cnt==MAX_WAIT and b_req=1.
//  - wait_cnt: +1 each cycle b_req=1 and b_gnt=0 (saturates at MAX_WAIT); cleared on b_gnt or b_req=0.
//    Locked cycles also count. Forcing applies only in IDLE; a lock is never preempted.
//  - Memory drive: mem_* from the granted port; mem_read=~we, mem_write=we.
//    No grant: mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
//  - Range: addr >= MEM_SIZE -> gnt still 1, mem_read=mem_write=0.
//    Next cycle: x_err=1, and x_rvalid=1 with x_rdata=0 if it was a read.
//  - Latency: write committed at grant edge. Read data = mem_read_data captured at grant edge,
//    rvalid 1 cycle later.
//    Back-to-back grants give 1 access/cycle. A write then read to the same address by any
//    port returns the new data.
//  - Simultaneous a_req & b_req with both lock: the winner locks; the loser waits.
//  - Lock has no cycle limit.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined: IDLE priority is round-robin.
//    - prio toggles to the other port after every grant in IDLE.
//    - The starvation force still applies, symmetric: A also has its own wait counter.
//  Undefined: fixed A>B priority plus B-only starvation counter, as above.
// TESTING
//  1. Reset, A read addr 2 with DMem[2]=10 -> a_gnt same cycle, next cycle a_rvalid=1, a_rdata=10.
//  2. a_req and b_req held 6 cycles, fixed prio, MAX_WAIT=4.
//     -> grants A,A,A,A,B,A; wait_cnt clears on the B grant.
//  3. A write 55 @5 with lock, then A read @5 next cycle; b_req asserted throughout.
//     -> B denied both cycles; a_rdata=55.
//  4. B write addr 200 -> b_gnt=1, mem_write=0, b_err pulse next cycle, memory unchanged.
//  5. A read granted, rst=0 before next edge -> a_rvalid stays 0; all outputs 0 during reset.
//  6. DMEM_ARB_RR_EN, both requesting continuously -> grants alternate A,B,A,B; A first after reset.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Request/response and DataMemory pin bundle shared by the two DataMemory requesters and the arbiter.
// Master = requester/memory side (testbench or SoC glue), slave = arbiter.
interface dmem_arbiter_if;
  logic        a_req, a_we, a_lock;
  logic [31:0] a_addr, a_wdata;
  logic        a_gnt, a_rvalid, a_err;
  logic [31:0] a_rdata;

  logic        b_req, b_we, b_lock;
  logic [31:0] b_addr, b_wdata;
  logic        b_gnt, b_rvalid, b_err;
  logic [31:0] b_rdata;

  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;

  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    input  a_gnt, a_rvalid, a_err, a_rdata,
    input  b_gnt, b_rvalid, b_err, b_rdata,
    input  mem_address, mem_write_data, mem_read, mem_write,
    output mem_read_data
  );

  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    output a_gnt, a_rvalid, a_err, a_rdata,
    output b_gnt, b_rvalid, b_err, b_rdata,
    output mem_address, mem_write_data, mem_read, mem_write,
    input  mem_read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU port A, loader/DMA port B) for the single-port DataMemory, with lock and anti-starvation.
// Grant is combinational, access completes at the grant edge; rvalid/err/rdata one cycle later.
// Losing port simply stays un-granted; DMEM_ARB_RR_EN selects round-robin IDLE priority with symmetric starvation.
module dmem_arbiter #(
  parameter int MEM_SIZE = 128,
  parameter int MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  localparam logic [3:0]  WAIT_MAX = 4'(MAX_WAIT);
  localparam logic [31:0] ADDR_LIM = 32'(MEM_SIZE);

  state_t     state, state_nxt;
  logic [3:0] b_wait, b_wait_nxt;
  logic       a_gnt, b_gnt;
  logic       a_oor, b_oor;
  logic       b_force;

  assign a_oor   = bus.a_addr >= ADDR_LIM;
  assign b_oor   = bus.b_addr >= ADDR_LIM;
  assign b_force = bus.b_req && (b_wait == WAIT_MAX);

`ifdef DMEM_ARB_RR_EN
  logic [3:0] a_wait, a_wait_nxt;
  logic       a_force;
  logic       prio_b, prio_b_nxt;

  assign a_force = bus.a_req && (a_wait == WAIT_MAX);
`endif

  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    state_nxt = IDLE;
    case (state)
      LOCK_A: a_gnt = bus.a_req;
      LOCK_B: b_gnt = bus.b_req;
      default: begin
`ifdef DMEM_ARB_RR_EN
        if (a_force && b_force) begin
          a_gnt = ~prio_b;
          b_gnt = prio_b;
        end else if (b_force) begin
          b_gnt = 1'b1;
        end else if (a_force) begin
          a_gnt = 1'b1;
        end else if (bus.a_req && bus.b_req) begin
          a_gnt = ~prio_b;
          b_gnt = prio_b;
        end else begin
          a_gnt = bus.a_req;
          b_gnt = bus.b_req;
        end
`else
        if (b_force) begin
          b_gnt = 1'b1;
        end else if (bus.a_req) begin
          a_gnt = 1'b1;
        end else begin
          b_gnt = bus.b_req;
        end
`endif
      end
    endcase
    // Nothing may reach the memory while reset is held, even with requests pending.
    if (!rst) begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
    end
    if (a_gnt && bus.a_lock) begin
      state_nxt = LOCK_A;
    end else if (b_gnt && bus.b_lock) begin
      state_nxt = LOCK_B;
    end
  end

  always_comb begin
    b_wait_nxt = 4'd0;
    if (bus.b_req && !b_gnt) begin
      b_wait_nxt = (b_wait == WAIT_MAX) ? b_wait : b_wait + 4'd1;
    end
`ifdef DMEM_ARB_RR_EN
    a_wait_nxt = 4'd0;
    if (bus.a_req && !a_gnt) begin
      a_wait_nxt = (a_wait == WAIT_MAX) ? a_wait : a_wait + 4'd1;
    end
    prio_b_nxt = prio_b;
    if (state == IDLE && (a_gnt || b_gnt)) begin
      prio_b_nxt = a_gnt;
    end
`endif
  end

  always_comb begin
    bus.mem_address    = 32'd0;
    bus.mem_write_data = 32'd0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    if (a_gnt) begin
      bus.mem_address    = bus.a_addr;
      bus.mem_write_data = bus.a_wdata;
      bus.mem_read       = ~bus.a_we & ~a_oor;
      bus.mem_write      = bus.a_we & ~a_oor;
    end else if (b_gnt) begin
      bus.mem_address    = bus.b_addr;
      bus.mem_write_data = bus.b_wdata;
      bus.mem_read       = ~bus.b_we & ~b_oor;
      bus.mem_write      = bus.b_we & ~b_oor;
    end
  end

  assign bus.a_gnt = a_gnt;
  assign bus.b_gnt = b_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      b_wait <= 4'd0;
`ifdef DMEM_ARB_RR_EN
      a_wait <= 4'd0;
      prio_b <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      b_wait <= b_wait_nxt;
`ifdef DMEM_ARB_RR_EN
      a_wait <= a_wait_nxt;
      prio_b <= prio_b_nxt;
`endif
    end
  end

  // Out-of-range reads still answer with rvalid so the requester never waits forever; data is forced to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.a_rvalid <= 1'b0;
      bus.a_err    <= 1'b0;
      bus.a_rdata  <= 32'd0;
      bus.b_rvalid <= 1'b0;
      bus.b_err    <= 1'b0;
      bus.b_rdata  <= 32'd0;
    end else begin
      bus.a_rvalid <= a_gnt & ~bus.a_we;
      bus.a_err    <= a_gnt & a_oor;
      bus.b_rvalid <= b_gnt & ~bus.b_we;
      bus.b_err    <= b_gnt & b_oor;
      if (a_gnt && !bus.a_we) begin
        bus.a_rdata <= a_oor ? 32'd0 : bus.mem_read_data;
      end
      if (b_gnt && !bus.b_we) begin
        bus.b_rdata <= b_oor ? 32'd0 : bus.mem_read_data;
      end
    end
  end

endmodule
